ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the CPU to the keyboard over the same ps2c/ps2d pair the keyboard receiver listens on. The PS/2 lines are open-drain, so the block only pulls them low through output enables and leaves the pad tristate logic at top level. `busy` gates the receiver so it ignores the frame being transmitted.

---
 rtl/ps2_tx.sv | 169 ++++++++++++++++
 tb/tb_ps2_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter with open-drain enables
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] din,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int MAX_V = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
    localparam int TW    = $clog2(MAX_V + 1);

    localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] RTS_LAST = TW'(RTS_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state;
    logic          c_meta, c_sync, c_prev;
    logic          d_meta, d_sync;
    logic [9:0]    frame;
    logic [3:0]    edge_cnt;
    logic [TW-1:0] tmr;
    logic          fall;
    logic          timeout;
    logic          device_phase;

    // Two-stage synchronizers on both pins plus a delayed clock copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            c_meta <= 1'b1;
            c_sync <= 1'b1;
            c_prev <= 1'b1;
            d_meta <= 1'b1;
            d_sync <= 1'b1;
        end else begin
            c_meta <= ps2c;
            c_sync <= c_meta;
            c_prev <= c_sync;
            d_meta <= ps2d;
            d_sync <= d_meta;
        end
    end

    assign fall         = c_prev & ~c_sync;
    assign device_phase = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
    assign timeout      = device_phase && (tmr == TO_LAST);

    // Transmit sequencer: inhibit, request-to-send, clocked bits, ack, bus-idle wait
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            frame    <= '0;
            edge_cnt <= '0;
            tmr      <= '0;
        end else begin
            done <= 1'b0;
            if (timeout) begin
                // The device stopped clocking: release the bus and give up
                err     <= 1'b1;
                busy    <= 1'b0;
                ps2c_oe <= 1'b0;
                ps2d_oe <= 1'b0;
                state   <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b0;
                        busy    <= 1'b0;
                        if (wr) begin
                            frame    <= {1'b1, ~^din, din};
                            err      <= 1'b0;
                            edge_cnt <= '0;
                            tmr      <= '0;
                            busy     <= 1'b1;
                            ps2c_oe  <= 1'b1;
                            state    <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (tmr == INH_LAST) begin
                            tmr     <= '0;
                            ps2d_oe <= 1'b1;
                            state   <= S_RTS;
                        end else begin
                            tmr <= tmr + TW'(1);
                        end
                    end
                    S_RTS: begin
                        if (tmr == RTS_LAST) begin
                            tmr     <= '0;
                            ps2c_oe <= 1'b0;
                            state   <= S_SEND;
                        end else begin
                            tmr <= tmr + TW'(1);
                        end
                    end
                    S_SEND: begin
                        tmr <= tmr + TW'(1);
                        if (fall) begin
                            // The start bit is already on the line; each fall presents the next bit
                            ps2d_oe  <= ~frame[0];
                            frame    <= {1'b0, frame[9:1]};
                            edge_cnt <= edge_cnt + 4'd1;
                            if (edge_cnt == 4'd9) begin
                                state <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        tmr     <= tmr + TW'(1);
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b0;
                        if (fall) begin
                            edge_cnt <= edge_cnt + 4'd1;
                            if (d_sync) begin
                                err   <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end else begin
                                state <= S_WAIT_IDLE;
                            end
                        end
                    end
                    S_WAIT_IDLE: begin
                        tmr <= tmr + TW'(1);
                        if (c_sync && d_sync) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - randomized self-checking bench for ps2_tx with a PS/2 device model
module tb_ps2_tx;

    localparam int INH = 20;
    localparam int RTS = 4;
    localparam int TO  = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ps2c, ps2d;
    logic       ps2c_oe, ps2d_oe, busy, done, err;
    logic       dev_c = 1'b1;
    logic       dev_d = 1'b1;

    int checks   = 0;
    int failures = 0;
    int done_count = 0;

    // Open-drain wired-AND with pull-ups
    assign ps2c = ~ps2c_oe & dev_c;
    assign ps2d = ~ps2d_oe & dev_d;

    ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES(RTS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr(wr),
        .din(din),
        .ps2c(ps2c),
        .ps2d(ps2d),
        .ps2c_oe(ps2c_oe),
        .ps2d_oe(ps2d_oe),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Count done pulses independently of the test tasks
    always @(posedge clk) begin
        if (done === 1'b1) done_count <= done_count + 1;
    end

    // Expected line levels before falls 1..11: start, d0..d7, odd parity, stop
    function automatic logic [10:0] model_bits(input logic [7:0] d);
        int  ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_wr(input logic [7:0] d);
        wr  = 1'b1;
        din = d;
        tick(1);
        wr  = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    // Device: waits for clock release, then issues nf falls sampling the data line before each
    task automatic dev_frame(input int nf, input bit ack, output logic [10:0] bits);
        int w;
        bits = '0;
        w = 0;
        while (ps2c_oe !== 1'b0 && w < 200) begin
            tick(1);
            w++;
        end
        if (w >= 200) begin
            checks++;
            failures++;
            $display("FAIL dev_release: ps2c_oe=%b after %0d cycles, required 0", ps2c_oe, w);
        end
        for (int k = 0; k < nf; k++) begin
            tick(15);
            bits[k] = ps2d;
            if (k == 10 && ack) dev_d = 1'b0;
            tick(5);
            dev_c = 1'b0;
            if (k == nf - 1 && nf < 11) begin
                tick(6);
                return;
            end
            tick(20);
            dev_c = 1'b1;
        end
        tick(3);
        dev_d = 1'b1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            tick(1);
            cyc++;
        end
    endtask

    task automatic test_reset();
        pulse_rst();
        tick(1);
        checks++; if (ps2c_oe !== 1'b0) begin failures++; $display("FAIL reset_ps2c_oe: got %b want 0", ps2c_oe); end
        checks++; if (ps2d_oe !== 1'b0) begin failures++; $display("FAIL reset_ps2d_oe: got %b want 0", ps2d_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
        // reset and wr together: reset wins
        rst = 1'b1; wr = 1'b1; din = 8'hFF;
        tick(1);
        rst = 1'b0; wr = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b0 || ps2c_oe !== 1'b0) begin failures++; $display("FAIL reset_vs_wr: busy=%b ps2c_oe=%b want 0 0", busy, ps2c_oe); end
        // reset during inhibit releases the clock next cycle
        do_wr(8'hA5);
        tick(3);
        checks++; if (ps2c_oe !== 1'b1) begin failures++; $display("FAIL inhibit_pre_rst: ps2c_oe=%b want 1", ps2c_oe); end
        pulse_rst();
        checks++; if (ps2c_oe !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_in_inhibit: ps2c_oe=%b busy=%b want 0 0", ps2c_oe, busy); end
    endtask

    task automatic test_inhibit_rts();
        logic [10:0] bits;
        int cyc;
        int dc0;
        logic exp_c, exp_d;
        do_wr(8'hED);
        for (int c = 1; c <= 25; c++) begin
            exp_c = (c <= INH + RTS) ? 1'b1 : 1'b0;
            exp_d = (c >= INH + 1) ? 1'b1 : 1'b0;
            checks++;
            if (ps2c_oe !== exp_c || ps2d_oe !== exp_d || busy !== 1'b1) begin
                failures++;
                $display("FAIL inhibit_rts cycle %0d: c_oe=%b d_oe=%b busy=%b want %b %b 1", c, ps2c_oe, ps2d_oe, busy, exp_c, exp_d);
            end
            if (c < 25) tick(1);
        end
        dc0 = done_count;
        dev_frame(11, 1'b1, bits);
        checks++; if (bits !== 11'h7DA) begin failures++; $display("FAIL ed_bits: got %h want 7da", bits); end
        checks++; if (bits !== model_bits(8'hED)) begin failures++; $display("FAIL ed_model: got %h want %h", bits, model_bits(8'hED)); end
        wait_done(cyc);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL ed_done: done=%b busy=%b err=%b want 1 0 0", done, busy, err); end
        tick(1);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL ed_done_width: done=%b want 0", done); end
        tick(1);
        checks++; if (done_count !== dc0 + 1) begin failures++; $display("FAIL ed_done_count: got %0d want %0d", done_count - dc0, 1); end
    endtask

    task automatic test_parity();
        logic [10:0] bits;
        logic [7:0] vals [2];
        logic pexp [2];
        int cyc;
        vals[0] = 8'h00; pexp[0] = 1'b1;
        vals[1] = 8'h07; pexp[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            do_wr(vals[i]);
            dev_frame(11, 1'b1, bits);
            checks++; if (bits[9] !== pexp[i]) begin failures++; $display("FAIL parity din=%h: got %b want %b", vals[i], bits[9], pexp[i]); end
            checks++; if (bits !== model_bits(vals[i])) begin failures++; $display("FAIL parity_frame din=%h: got %h want %h", vals[i], bits, model_bits(vals[i])); end
            wait_done(cyc);
            checks++; if (done !== 1'b1) begin failures++; $display("FAIL parity_done din=%h: done=%b want 1", vals[i], done); end
            tick(2);
        end
    endtask

    task automatic test_random_frames();
        logic [10:0] bits;
        logic [7:0] d;
        bit ack;
        int cyc;
        int dc0;
        for (int i = 0; i < 6; i++) begin
            d   = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            dc0 = done_count;
            do_wr(d);
            dev_frame(11, ack, bits);
            checks++; if (bits !== model_bits(d)) begin failures++; $display("FAIL rand_frame din=%h: got %h want %h", d, bits, model_bits(d)); end
            if (ack) wait_done(cyc);
            tick(3);
            checks++;
            if (err !== !ack || busy !== 1'b0 || (done_count - dc0) !== int'(ack)) begin
                failures++;
                $display("FAIL rand_outcome din=%h ack=%0d: err=%b busy=%b dones=%0d", d, ack, err, busy, done_count - dc0);
            end
        end
    endtask

    task automatic test_nack();
        logic [10:0] bits;
        int dc0;
        dc0 = done_count;
        do_wr(8'hFF);
        dev_frame(11, 1'b0, bits);
        checks++; if (bits !== model_bits(8'hFF)) begin failures++; $display("FAIL nack_frame: got %h want %h", bits, model_bits(8'hFF)); end
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL nack_err: err=%b busy=%b want 1 0", err, busy); end
        checks++; if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0) begin failures++; $display("FAIL nack_oe: c=%b d=%b want 0 0", ps2c_oe, ps2d_oe); end
        tick(5);
        checks++; if (done_count !== dc0 || err !== 1'b1) begin failures++; $display("FAIL nack_done: dones=%0d err=%b want 0 1", done_count - dc0, err); end
    endtask

    task automatic test_timeout();
        int w;
        int n;
        do_wr(8'h42);
        w = 0;
        while (ps2c_oe !== 1'b0 && w < 200) begin tick(1); w++; end
        n = 0;
        while (err !== 1'b1 && n < TO + 200) begin tick(1); n++; end
        checks++; if (n !== TO) begin failures++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO); end
        checks++; if (busy !== 1'b0 || ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0) begin failures++; $display("FAIL timeout_release: busy=%b c=%b d=%b want 0 0 0", busy, ps2c_oe, ps2d_oe); end
        do_wr(8'h11);
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL timeout_clear: err=%b busy=%b want 0 1", err, busy); end
        pulse_rst();
    endtask

    task automatic test_busy_ignore();
        logic [10:0] bits;
        int cyc;
        do_wr(8'h3C);
        tick(5);
        wr = 1'b1; din = 8'h55;
        tick(1);
        wr = 1'b0; din = 8'h00;
        dev_frame(11, 1'b1, bits);
        checks++; if (bits !== model_bits(8'h3C)) begin failures++; $display("FAIL busy_ignore: got %h want %h", bits, model_bits(8'h3C)); end
        wait_done(cyc);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL busy_ignore_done: done=%b want 1", done); end
        tick(2);
    endtask

    task automatic test_reset_busy();
        logic [10:0] bits;
        do_wr(8'h2C);
        dev_frame(5, 1'b1, bits);
        checks++; if (ps2d_oe !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL pre_rst_state: d_oe=%b busy=%b want 1 1", ps2d_oe, busy); end
        pulse_rst();
        checks++; if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_frame: c=%b d=%b busy=%b want 0 0 0", ps2c_oe, ps2d_oe, busy); end
        dev_c = 1'b1;
        tick(5);
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits;
        logic [7:0] a, b;
        int cyc;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        do_wr(a);
        dev_frame(11, 1'b1, bits);
        checks++; if (bits !== model_bits(a)) begin failures++; $display("FAIL b2b_first: got %h want %h", bits, model_bits(a)); end
        wait_done(cyc);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done1: done=%b want 1", done); end
        do_wr(b);
        checks++; if (busy !== 1'b1 || ps2c_oe !== 1'b1) begin failures++; $display("FAIL b2b_accept: busy=%b c_oe=%b want 1 1", busy, ps2c_oe); end
        dev_frame(11, 1'b1, bits);
        checks++; if (bits !== model_bits(b)) begin failures++; $display("FAIL b2b_second: got %h want %h", bits, model_bits(b)); end
        wait_done(cyc);
        checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL b2b_done2: done=%b err=%b want 1 0", done, err); end
        tick(2);
    endtask

    initial begin
        tick(1);
        test_reset();
        test_inhibit_rts();
        test_parity();
        test_nack();
        test_timeout();
        test_busy_ignore();
        test_reset_busy();
        test_back_to_back();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
